// File: rtl/ped_phase_sched.sv
// rtl/ped_phase_sched.sv - intersection phase scheduler for main road and two crosswalks
//
// Sequences GREEN -> YELLOW -> ALL_RED1 -> WALK -> FLASH -> ALL_RED2 -> GREEN,
// latching crosswalk requests and holding main green for at least MIN_GREEN ticks.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   tick         timing enable; every duration counts cycles with tick=1
//   ped_btn_a/b  crosswalk request levels, sampled every clk
//   main_light   00 red, 01 green, 10 yellow
//   ped_light_a/b 00 don't-walk, 01 walk, 10 flash
//   ped_wait_a/b request pending, not yet served
//   busy         high in every state except GREEN
module ped_phase_sched #(
  parameter int MIN_GREEN = 20,
  parameter int YELLOW_T  = 5,
  parameter int ALL_RED_T = 2,
  parameter int WALK_T    = 15,
  parameter int FLASH_T   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_btn_a,
  input  logic       ped_btn_b,
  output logic [1:0] main_light,
  output logic [1:0] ped_light_a,
  output logic [1:0] ped_light_b,
  output logic       ped_wait_a,
  output logic       ped_wait_b,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_GREEN    = 3'd0,
    S_YELLOW   = 3'd1,
    S_ALL_RED1 = 3'd2,
    S_WALK     = 3'd3,
    S_FLASH    = 3'd4,
    S_ALL_RED2 = 3'd5
  } state_t;

  // Timer value on the final tick of each phase.
  localparam logic [7:0] GREEN_LAST  = 8'(MIN_GREEN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] RED_LAST    = 8'(ALL_RED_T - 1);
  localparam logic [7:0] WALK_LAST   = 8'(WALK_T - 1);
  localparam logic [7:0] FLASH_LAST  = 8'(FLASH_T - 1);

  state_t     state, state_n;
  logic [7:0] timer, timer_n;
  logic [1:0] pending, pending_n;
  logic [1:0] served, served_n;
  logic [1:0] btn, ignore_mask;
  logic [1:0] main_n, ped_a_n, ped_b_n;
  logic [7:0] last;
  logic       phase_done;

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    served_n    = served;
    btn         = {ped_btn_b, ped_btn_a};
    // A crosswalk that is currently walking/flashing ignores its own button.
    ignore_mask = (state == S_WALK || state == S_FLASH) ? served : 2'b00;
    pending_n   = pending | (btn & ~ignore_mask);

    case (state)
      S_YELLOW:   last = YELLOW_LAST;
      S_WALK:     last = WALK_LAST;
      S_FLASH:    last = FLASH_LAST;
      S_GREEN:    last = GREEN_LAST;
      default:    last = RED_LAST;
    endcase
    phase_done = tick && (timer == last);

    case (state)
      S_GREEN: begin
        // Timer saturates at the minimum; exit waits for a request, including
        // one latched on this very cycle.
        if (phase_done) begin
          if (pending_n != 2'b00) begin
            state_n = S_YELLOW;
            timer_n = '0;
          end
        end else if (tick) begin
          timer_n = timer + 8'd1;
        end
      end
      S_YELLOW, S_ALL_RED1, S_WALK, S_FLASH, S_ALL_RED2: begin
        if (phase_done) begin
          timer_n = '0;
          case (state)
            S_YELLOW:   state_n = S_ALL_RED1;
            S_ALL_RED1: begin
              state_n   = S_WALK;
              served_n  = pending_n;
              pending_n = 2'b00;
            end
            S_WALK:     state_n = S_FLASH;
            S_FLASH:    state_n = S_ALL_RED2;
            default: begin
              state_n  = S_GREEN;
              served_n = 2'b00;
            end
          endcase
        end else if (tick) begin
          timer_n = timer + 8'd1;
        end
      end
      default: begin
        state_n   = S_GREEN;
        timer_n   = '0;
        pending_n = 2'b00;
        served_n  = 2'b00;
      end
    endcase
  end

  // Output decode from the next state so the registered lights line up with it.
  always_comb begin
    main_n  = 2'b00;
    ped_a_n = 2'b00;
    ped_b_n = 2'b00;
    case (state_n)
      S_GREEN:  main_n = 2'b01;
      S_YELLOW: main_n = 2'b10;
      S_WALK: begin
        ped_a_n = served_n[0] ? 2'b01 : 2'b00;
        ped_b_n = served_n[1] ? 2'b01 : 2'b00;
      end
      S_FLASH: begin
        ped_a_n = served_n[0] ? 2'b10 : 2'b00;
        ped_b_n = served_n[1] ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_GREEN;
      timer       <= '0;
      pending     <= 2'b00;
      served      <= 2'b00;
      main_light  <= 2'b01;
      ped_light_a <= 2'b00;
      ped_light_b <= 2'b00;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      pending     <= pending_n;
      served      <= served_n;
      main_light  <= main_n;
      ped_light_a <= ped_a_n;
      ped_light_b <= ped_b_n;
      busy        <= (state_n != S_GREEN);
    end
  end

  assign ped_wait_a = pending[0];
  assign ped_wait_b = pending[1];

endmodule

// File: tb/tb_ped_phase_sched.sv
// tb/tb_ped_phase_sched.sv - self-checking bench for ped_phase_sched
module tb_ped_phase_sched;

  localparam int MIN_GREEN = 20;
  localparam int YELLOW_T  = 5;
  localparam int ALL_RED_T = 2;
  localparam int WALK_T    = 15;
  localparam int FLASH_T   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       ped_btn_a = 1'b0;
  logic       ped_btn_b = 1'b0;
  logic [1:0] main_light, ped_light_a, ped_light_b;
  logic       ped_wait_a, ped_wait_b, busy;

  int tests = 0;
  int fails = 0;

  ped_phase_sched #(
    .MIN_GREEN(MIN_GREEN), .YELLOW_T(YELLOW_T), .ALL_RED_T(ALL_RED_T),
    .WALK_T(WALK_T), .FLASH_T(FLASH_T)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ped_btn_a(ped_btn_a), .ped_btn_b(ped_btn_b),
    .main_light(main_light), .ped_light_a(ped_light_a), .ped_light_b(ped_light_b),
    .ped_wait_a(ped_wait_a), .ped_wait_b(ped_wait_b), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: phase index 0..5 (green, yellow, red, walk, flash, red) and
  // the number of ticks already spent in that phase.
  int       m_phase = 0;
  int       m_el    = 0;
  bit [1:0] m_pend  = 2'b00;
  bit [1:0] m_serv  = 2'b00;

  function automatic int phase_len(input int p);
    case (p)
      0: return MIN_GREEN;
      1: return YELLOW_T;
      3: return WALK_T;
      4: return FLASH_T;
      default: return ALL_RED_T;
    endcase
  endfunction

  always @(posedge clk) begin
    bit [1:0] req;
    if (rst) begin
      m_phase = 0; m_el = 0; m_pend = 2'b00; m_serv = 2'b00;
    end else begin
      req = {ped_btn_b, ped_btn_a};
      if (m_phase == 3 || m_phase == 4) req = req & ~m_serv;
      m_pend = m_pend | req;
      if (tick) begin
        if (m_el + 1 >= phase_len(m_phase) && (m_phase != 0 || m_pend != 2'b00)) begin
          if (m_phase == 2) begin m_serv = m_pend; m_pend = 2'b00; end
          if (m_phase == 5) m_serv = 2'b00;
          m_phase = (m_phase + 1) % 6;
          m_el = 0;
        end else begin
          m_el = m_el + 1;
        end
      end
    end
  end

  function automatic logic [8:0] model_vec();
    logic [1:0] mn, pa, pb;
    mn = (m_phase == 0) ? 2'd1 : (m_phase == 1) ? 2'd2 : 2'd0;
    pa = 2'd0; pb = 2'd0;
    if (m_phase == 3) begin pa = m_serv[0] ? 2'd1 : 2'd0; pb = m_serv[1] ? 2'd1 : 2'd0; end
    if (m_phase == 4) begin pa = m_serv[0] ? 2'd2 : 2'd0; pb = m_serv[1] ? 2'd2 : 2'd0; end
    return {mn, pa, pb, m_pend[0], m_pend[1], (m_phase != 0)};
  endfunction

  logic       chk_en = 1'b1;
  int         scn = 0;
  int         cyc = 0;

  always @(negedge clk) begin
    logic [8:0] got, exp_v;
    if (chk_en) begin
      got   = {main_light, ped_light_a, ped_light_b, ped_wait_a, ped_wait_b, busy};
      exp_v = model_vec();
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL outputs scn=%0d cyc=%0d got=%b expected=%b (main,pa,pb,wa,wb,busy)",
                 scn, cyc, got, exp_v);
      end
    end
  end

  // Hand-computed expectations: scenario, cycle, field, value.
  // Fields: 0 main, 1 ped_a, 2 ped_b, 3 wait_a, 4 wait_b, 5 busy.
  typedef struct { int s; int c; int f; int v; } lit_t;
  lit_t lits[$];

  task automatic add(input int s, input int c, input int f, input int v);
    lit_t e;
    e.s = s; e.c = c; e.f = f; e.v = v;
    lits.push_back(e);
  endtask

  function automatic int field(input int f);
    case (f)
      0: return int'(main_light);
      1: return int'(ped_light_a);
      2: return int'(ped_light_b);
      3: return int'(ped_wait_a);
      4: return int'(ped_wait_b);
      default: return int'(busy);
    endcase
  endfunction

  task automatic run(input int s, input int n);
    scn = s;
    rst = 1'b1; tick = 1'b1; ped_btn_a = 1'b0; ped_btn_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < n; c++) begin
      cyc = c;
      foreach (lits[i]) begin
        if (lits[i].s == s && lits[i].c == c) begin
          tests++;
          if (field(lits[i].f) != lits[i].v) begin
            fails++;
            $display("FAIL literal scn=%0d cyc=%0d field=%0d got=%0d expected=%0d",
                     s, c, lits[i].f, field(lits[i].f), lits[i].v);
          end
        end
      end
      if (s == 7) begin
        tick      = ($urandom_range(0, 2) != 0);
        ped_btn_a = ($urandom_range(0, 24) == 0);
        ped_btn_b = ($urandom_range(0, 24) == 0);
        rst       = ($urandom_range(0, 599) == 0);
      end else begin
        tick      = (s == 6) ? (c % 4 == 0) : 1'b1;
        ped_btn_a = ((s >= 2 && s <= 4) && c == 5) || (s == 4 && c == 30) || (s == 6 && c == 1);
        ped_btn_b = (s == 3 && c == 26) || (s == 4 && c == 30) || (s == 5 && (c == 5 || c == 35));
        rst       = (s == 5 && c == 30);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    add(1, 0, 0, 1);   add(1, 0, 5, 0);   add(1, 0, 3, 0);   add(1, 199, 0, 1); add(1, 199, 1, 0);
    add(2, 5, 3, 0);   add(2, 6, 3, 1);   add(2, 19, 0, 1);  add(2, 20, 0, 2);  add(2, 20, 5, 1);
    add(2, 24, 0, 2);  add(2, 25, 0, 0);  add(2, 26, 3, 1);  add(2, 27, 1, 1);  add(2, 27, 3, 0);
    add(2, 27, 2, 0);  add(2, 41, 1, 1);  add(2, 42, 1, 2);  add(2, 46, 1, 2);  add(2, 47, 1, 0);
    add(2, 48, 0, 0);  add(2, 49, 0, 1);  add(2, 49, 5, 0);
    add(3, 26, 4, 0);  add(3, 27, 2, 1);  add(3, 27, 1, 1);  add(3, 27, 4, 0);  add(3, 42, 2, 2);
    add(3, 46, 2, 2);  add(3, 47, 2, 0);
    add(4, 31, 3, 0);  add(4, 31, 4, 1);  add(4, 49, 0, 1);  add(4, 68, 0, 1);  add(4, 69, 0, 2);
    add(4, 75, 2, 0);  add(4, 76, 2, 1);  add(4, 76, 1, 0);  add(4, 76, 4, 0);  add(4, 90, 2, 1);
    add(4, 91, 2, 2);
    add(5, 30, 2, 1);  add(5, 31, 0, 1);  add(5, 31, 2, 0);  add(5, 31, 4, 0);  add(5, 31, 5, 0);
    add(5, 50, 0, 1);  add(5, 51, 0, 2);
    add(6, 1, 3, 0);   add(6, 2, 3, 1);   add(6, 76, 0, 1);  add(6, 77, 0, 2);  add(6, 96, 0, 2);
    add(6, 97, 0, 0);  add(6, 104, 1, 0); add(6, 105, 1, 1); add(6, 105, 3, 0); add(6, 164, 1, 1);
    add(6, 165, 1, 2); add(6, 184, 1, 2); add(6, 185, 1, 0); add(6, 192, 0, 0); add(6, 193, 0, 1);

    run(1, 200);
    run(2, 60);
    run(3, 60);
    run(4, 100);
    run(5, 60);
    run(6, 200);
    run(7, 3000);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
